// File: rtl/bus_req_encoder_16_4.sv
// rtl/bus_req_encoder_16_4.sv - sequential 16-to-4 request encoder, lowest index first
module bus_req_encoder_16_4 #(
  parameter int IDX_W = 4,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_code,
  output logic             busy,
  output logic [WIDTH-1:0] pending,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending_nxt;
  logic [WIDTH-1:0] pending_drop;
  logic             done_nxt;
  logic [IDX_W-1:0] low_idx;

  // Priority encode the lowest set bit of the registered pending word.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Drop the lowest set bit: x & (x - 1) clears exactly the bit at low_idx.
  always_comb begin
    pending_drop = pending & (pending - WIDTH'(1));
  end

  // Next-state, next-pending and done pulse generation.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (req_in != '0) begin
            pending_nxt = req_in;
            state_nxt   = EMIT;
          end else begin
            // An empty word completes immediately with nothing to emit.
            done_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        // Loads are ignored here; only consumer acceptance advances.
        if (out_ready) begin
          pending_nxt = pending_drop;
          if (pending_drop == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // State, pending word and done register with asynchronous clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      pending <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      done    <= done_nxt;
    end
  end

  // Outputs derive only from registered state, so no input reaches an output combinationally.
  always_comb begin
    out_valid = (state == EMIT);
    busy      = (state == EMIT);
    out_code  = (state == EMIT) ? low_idx : '0;
  end

endmodule

// File: tb/tb_bus_req_encoder_16_4.sv
// tb/tb_bus_req_encoder_16_4.sv - directed self-checking bench for bus_req_encoder_16_4
module tb_bus_req_encoder_16_4;

  logic        clock;
  logic        clear;
  logic        load;
  logic [15:0] req_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        busy;
  logic [15:0] pending;
  logic        done;

  int total;
  int bad;

  bus_req_encoder_16_4 #(.IDX_W(4), .WIDTH(16)) dut (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .busy      (busy),
    .pending   (pending),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (pending !== 16'h0000) begin bad++; $display("FAIL reset_pending got=%h exp=0000", pending); end
    total++; if (out_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h exp=0", out_code); end
  endtask

  task automatic test_zero_word();
    load = 1'b1; req_in = 16'h0000;
    step();
    load = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_end got=%b exp=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_sparse();
    logic [3:0]  codes [4];
    logic [15:0] pends [4];
    codes = '{4'd0, 4'd5, 4'd10, 4'd15};
    pends = '{16'h8421, 16'h8420, 16'h8400, 16'h8000};
    out_ready = 1'b1; load = 1'b1; req_in = 16'h8421;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sparse_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_code !== codes[i]) begin bad++; $display("FAIL sparse_code[%0d] got=%0d exp=%0d", i, out_code, codes[i]); end
      total++; if (pending !== pends[i]) begin bad++; $display("FAIL sparse_pending[%0d] got=%h exp=%h", i, pending, pends[i]); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL sparse_early_done[%0d] got=%b exp=0", i, done); end
      step();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sparse_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sparse_busy got=%b exp=0", busy); end
    total++; if (pending !== 16'h0000) begin bad++; $display("FAIL sparse_pending_end got=%h exp=0000", pending); end
    total++; if (out_code !== 4'h0) begin bad++; $display("FAIL sparse_code_idle got=%h exp=0", out_code); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL sparse_done_once got=%b exp=0", done); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; load = 1'b1; req_in = 16'h0006;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_code !== 4'd1) begin bad++; $display("FAIL bp_code[%0d] got=%0d exp=1", i, out_code); end
      total++; if (pending !== 16'h0006) begin bad++; $display("FAIL bp_pending[%0d] got=%h exp=0006", i, pending); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      step();
    end
    out_ready = 1'b1;
    total++; if (out_code !== 4'd1) begin bad++; $display("FAIL bp_code_a got=%0d exp=1", out_code); end
    step();
    total++; if (out_code !== 4'd2) begin bad++; $display("FAIL bp_code_b got=%0d exp=2", out_code); end
    total++; if (pending !== 16'h0004) begin bad++; $display("FAIL bp_pending_b got=%h exp=0004", pending); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_load_while_busy();
    out_ready = 1'b1; load = 1'b1; req_in = 16'h0003;
    step();
    req_in = 16'h0100;
    total++; if (out_code !== 4'd0) begin bad++; $display("FAIL lwb_code0 got=%0d exp=0", out_code); end
    total++; if (pending !== 16'h0003) begin bad++; $display("FAIL lwb_pending0 got=%h exp=0003", pending); end
    step();
    load = 1'b0;
    total++; if (out_code !== 4'd1) begin bad++; $display("FAIL lwb_code1 got=%0d exp=1", out_code); end
    total++; if (pending !== 16'h0002) begin bad++; $display("FAIL lwb_pending1 got=%h exp=0002", pending); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL lwb_done got=%b exp=1", done); end
    total++; if (pending !== 16'h0000) begin bad++; $display("FAIL lwb_pending_end got=%h exp=0000", pending); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lwb_done_once got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lwb_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b1; load = 1'b1; req_in = 16'hFFFF;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_code !== 4'(i)) begin bad++; $display("FAIL rst_code[%0d] got=%0d exp=%0d", i, out_code, i); end
      step();
    end
    total++; if (pending !== 16'hFFF8) begin bad++; $display("FAIL rst_pending_pre got=%h exp=fff8", pending); end
    #2 clear = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    total++; if (pending !== 16'h0000) begin bad++; $display("FAIL rst_async_pending got=%h exp=0000", pending); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    total++; if (out_code !== 4'h0) begin bad++; $display("FAIL rst_async_code got=%h exp=0", out_code); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_hold_done got=%b exp=0", done); end
    clear = 1'b1;
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_release_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
    load = 1'b1; req_in = 16'h8000;
    step();
    load = 1'b0;
    total++; if (out_code !== 4'hF) begin bad++; $display("FAIL rst_code15 got=%h exp=f", out_code); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_valid15 got=%b exp=1", out_valid); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rst_done15 got=%b exp=1", done); end
    step();
  endtask

  task automatic test_full_word();
    out_ready = 1'b1; load = 1'b1; req_in = 16'hFFFF;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++; if (out_code !== 4'(i)) begin bad++; $display("FAIL full_code[%0d] got=%0d exp=%0d", i, out_code, i); end
      step();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; load = 1'b1; req_in = 16'h0010;
    step();
    load = 1'b0;
    total++; if (out_code !== 4'd4) begin bad++; $display("FAIL b2b_code4 got=%0d exp=4", out_code); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    load = 1'b1; req_in = 16'h0001;
    step();
    load = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    total++; if (out_code !== 4'd0) begin bad++; $display("FAIL b2b_code0 got=%0d exp=0", out_code); end
    total++; if (pending !== 16'h0001) begin bad++; $display("FAIL b2b_pending got=%h exp=0001", pending); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_gap got=%b exp=0", done); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done2_once got=%b exp=0", done); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    clear = 1'b0;
    load = 1'b0;
    req_in = 16'h0000;
    out_ready = 1'b0;
    step();
    step();
    test_reset();
    clear = 1'b1;
    step();
    test_zero_word();
    test_sparse();
    test_backpressure();
    test_load_while_busy();
    test_reset_mid_op();
    test_full_word();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
